// File: rtl/key_pkg.sv
// Shared definitions for the console key sequencer: key indices, FSM states,
// strobe bundle and the per-key strobe decode.
package key_pkg;

  localparam int KEY_LA    = 0;
  localparam int KEY_START = 1;
  localparam int KEY_DEP   = 2;
  localparam int KEY_EXAM  = 3;
  localparam int KEY_CONT  = 4;
  localparam int KEY_STOP  = 5;

  localparam logic [19:0] DEBOUNCE_DEF = 20'd200000;
  localparam logic [7:0]  TIMEOUT_DEF  = 8'd200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_REQ,
    ST_WAIT,
    ST_RELEASE
  } state_e;

  typedef struct packed {
    logic stop_req;
    logic set_run;
    logic clr_all;
    logic pc_inc;
    logic mem_rd;
    logic mem_wr;
    logic ma_from_pc;
    logic ld_pc_sr;
  } strobe_t;

  function automatic logic is_onehot(input logic [5:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

  // Pulses are OR-combined so coincident mftp pulses each get their actions.
  function automatic strobe_t key_strobes(input logic [5:0] k, input logic p0,
                                          input logic p1, input logic p2);
    strobe_t s;
    s.ld_pc_sr   = k[KEY_LA] & p1;
    s.clr_all    = k[KEY_START] & p0;
    s.ma_from_pc = (k[KEY_START] | k[KEY_DEP] | k[KEY_EXAM]) & p1;
    s.mem_wr     = k[KEY_DEP] & p1;
    s.mem_rd     = k[KEY_EXAM] & p1;
    s.pc_inc     = (k[KEY_DEP] | k[KEY_EXAM]) & p2;
    s.set_run    = (k[KEY_START] | k[KEY_CONT]) & p2;
    s.stop_req   = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key sample register plus saturating stability counter; stable_o is
// combinational and true for the one cycle the counter reaches DEBOUNCE-1.
module key_debounce
  import key_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] keys_i,
  input  logic       load_i,
  output logic [5:0] sample_o,
  output logic       stable_o,
  output logic       onehot_o,
  output logic       released_o
);

  logic [5:0]  sample_q, sample_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    if (load_i || (keys_i != sample_q)) begin
      sample_d = keys_i;
      cnt_d    = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      cnt_q    <= '0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sample_o   = sample_q;
  assign stable_o   = (keys_i == sample_q) && (cnt_q == DEBOUNCE - 20'd1);
  assign onehot_o   = is_onehot(sample_q);
  assign released_o = stable_o && (sample_q == '0);

endmodule

// File: rtl/key_control.sv
// Console key sequencer: one debounced key press -> one manual timing request,
// with registered one-cycle strobes issued the cycle after each mftp pulse.
module key_control
  import key_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE = DEBOUNCE_DEF,
  parameter logic [7:0]  TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] keys,
  input  logic       run,
  input  logic       mftp0,
  input  logic       mftp1,
  input  logic       mftp2,
  output logic       mft_req,
  output logic       ld_pc_sr,
  output logic       ma_from_pc,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic       pc_inc,
  output logic       clr_all,
  output logic       set_run,
  output logic       stop_req,
  output logic       key_err
);

  state_e     state_q, state_d;
  logic [5:0] key_q, key_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       req_q, req_d;
  logic       err_q, err_d;
  strobe_t    strb_q, strb_d;

  logic       db_load;
  logic [5:0] db_sample;
  logic       db_stable, db_onehot, db_released;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys_i     (keys),
    .load_i     (db_load),
    .sample_o   (db_sample),
    .stable_o   (db_stable),
    .onehot_o   (db_onehot),
    .released_o (db_released)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    tcnt_d  = tcnt_q;
    req_d   = req_q;
    err_d   = err_q;
    strb_d  = '0;
    db_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (keys != '0) begin
          db_load = 1'b1;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (db_stable) begin
          if (!db_onehot) begin
            state_d = ST_RELEASE;
          end else if (db_sample[KEY_STOP]) begin
            strb_d.stop_req = 1'b1;
            state_d         = ST_RELEASE;
          end else if (run) begin
            state_d = ST_RELEASE;
          end else begin
            key_d   = db_sample;
            err_d   = 1'b0;
            tcnt_d  = '0;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        strb_d = key_strobes(key_q, mftp0, mftp1, mftp2);
        if (state_q == ST_REQ) state_d = ST_WAIT;
        // mftp2 wins over a coincident timeout: the sequence did complete.
        if (mftp2) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end else if (tcnt_q == TIMEOUT - 8'd1) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (db_released) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_RELEASE) && (state_q != ST_RELEASE)) db_load = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
    end
  end

  assign mft_req = req_q;
  assign key_err = err_q;
  assign {stop_req, set_run, clr_all, pc_inc, mem_rd, mem_wr, ma_from_pc, ld_pc_sr} = strb_q;

endmodule

// File: tb/tb_key_control.sv
// Bench for key_control: directed press table plus random presses, each cycle
// compared against a timing model derived from the key/pulse action table.
module tb_key_control;

  localparam int DEB = 4;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] keys;
  logic       run;
  logic       mftp0, mftp1, mftp2;
  logic       mft_req, ld_pc_sr, ma_from_pc, mem_wr, mem_rd, pc_inc;
  logic       clr_all, set_run, stop_req, key_err;

  key_control #(.DEBOUNCE(20'd4), .TIMEOUT(8'd100)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .run(run),
    .mftp0(mftp0), .mftp1(mftp1), .mftp2(mftp2),
    .mft_req(mft_req), .ld_pc_sr(ld_pc_sr), .ma_from_pc(ma_from_pc),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .pc_inc(pc_inc), .clr_all(clr_all),
    .set_run(set_run), .stop_req(stop_req), .key_err(key_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Manual timing generator model: pulses at fixed offsets after mft_req rises.
  int   rise = -100000;
  logic req_prev = 1'b0;
  int   gd0 = 1, gd1 = 41, gd2 = 81;
  bit   gsilent = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) rise = -100000;
    else if (mft_req && !req_prev) rise = cyc;
    req_prev = mft_req;
    mftp0 = !gsilent && (cyc == rise + gd0);
    mftp1 = !gsilent && (cyc == rise + gd1);
    mftp2 = !gsilent && (cyc == rise + gd2);
  end

  // act[key][pulse]: strobes {stop,set,clr,inc,rd,wr,ma,ld} owed for that pulse
  logic [7:0] act[6][3];
  bit         err_model = 1'b0;
  int         scnt[8];
  int         nreq;

  typedef struct {
    logic [5:0] keys;
    bit         run;
    bit         bounce;
    bit         sil;
    int         d0, d1, d2, hold;
    logic [7:0] strb;
    int         nreq;
    bit         err;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic [5:0] k, bit r, bit b, bit s, int d0, int d1, int d2,
                              int hold, logic [7:0] strb, int nr, bit e);
    vec_t v;
    v.keys = k; v.run = r; v.bounce = b; v.sil = s;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.hold = hold;
    v.strb = strb; v.nreq = nr; v.err = e;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {mft_req, key_err, stop_req, set_run, clr_all, pc_inc, mem_rd, mem_wr,
            ma_from_pc, ld_pc_sr};
  endfunction

  // Expected {mft_req, key_err, strobes} j cycles after the press is first seen.
  function automatic logic [9:0] model(logic [5:0] k, bit r, int d0, int d1, int d2,
                                       bit sil, int j, bit errp);
    logic       req;
    logic       err;
    logic [7:0] s;
    int         ki;
    req = 1'b0; err = errp; s = '0; ki = 0;
    for (int i = 0; i < 6; i++) if (k[i]) ki = i;
    if ($countones(k) == 1) begin
      if (ki == 5) begin
        s[7] = (j == DEB);
      end else if (!r) begin
        if (j >= DEB) err = sil && (j >= DEB + TMO);
        if (sil) begin
          req = (j >= DEB) && (j < DEB + TMO);
        end else begin
          req = (j >= DEB) && (j <= DEB + d2);
          if (j == DEB + d0 + 1) s = s | act[ki][0];
          if (j == DEB + d1 + 1) s = s | act[ki][1];
          if (j == DEB + d2 + 1) s = s | act[ki][2];
        end
      end
    end
    return {req, err, s};
  endfunction

  task automatic check(input bit ok, input string nm, input int got, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic press(input logic [5:0] k, input bit r, input bit bounce, input bit sil,
                       input int d0, input int d1, input int d2, input int hold,
                       input string nm);
    int         base;
    logic [9:0] got, expv;
    gd0 = d0; gd1 = d1; gd2 = d2; gsilent = sil;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        keys = (i % 2 == 0) ? k : 6'b0;
        repeat (2) @(negedge clk);
      end
    end
    @(negedge clk);
    keys = k; run = r; base = cyc;
    for (int i = 0; i < 8; i++) scnt[i] = 0;
    nreq = 0;
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      got  = outs();
      expv = model(k, r, d0, d1, d2, sil, j, err_model);
      check(got == expv, $sformatf("%s_cyc%0d", nm, j), int'(got), int'(expv));
      for (int i = 0; i < 8; i++) if (got[i]) scnt[i]++;
      if (got[9]) nreq++;
    end
    if ($countones(k) == 1 && !k[5] && !r) err_model = sil;
    keys = '0;
    repeat (DEB + 4) @(negedge clk);
    check(outs() == {1'b0, err_model, 8'b0}, {nm, "_released"}, int'(outs()),
          int'({1'b0, err_model, 8'b0}));
    if (base < 0) check(1'b0, "base", base, 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) for (int p = 0; p < 3; p++) act[i][p] = '0;
    act[0][1] = 8'b0000_0001;
    act[1][0] = 8'b0010_0000; act[1][1] = 8'b0000_0010; act[1][2] = 8'b0100_0000;
    act[2][1] = 8'b0000_0110; act[2][2] = 8'b0001_0000;
    act[3][1] = 8'b0000_1010; act[3][2] = 8'b0001_0000;
    act[4][2] = 8'b0100_0000;

    tbl[0]  = mk(6'b000001, 0, 0, 0, 1, 41, 81, 112, 8'b0000_0001, 82, 0);
    tbl[1]  = mk(6'b000100, 0, 0, 0, 1, 41, 81, 112, 8'b0001_0110, 82, 0);
    tbl[2]  = mk(6'b000100, 0, 0, 0, 1, 41, 81, 112, 8'b0001_0110, 82, 0);
    tbl[3]  = mk(6'b001000, 0, 1, 0, 1, 41, 81, 112, 8'b0001_1010, 82, 0);
    tbl[4]  = mk(6'b000011, 0, 0, 0, 1, 41, 81, 112, 8'b0000_0000, 0, 0);
    tbl[5]  = mk(6'b010000, 1, 0, 0, 1, 41, 81, 112, 8'b0000_0000, 0, 0);
    tbl[6]  = mk(6'b100000, 1, 0, 0, 1, 41, 81, 1000, 8'b1000_0000, 0, 0);
    tbl[7]  = mk(6'b000010, 0, 0, 0, 1, 5, 5, 112, 8'b0110_0010, 6, 0);
    tbl[8]  = mk(6'b010000, 0, 0, 0, 1, 41, 81, 112, 8'b0100_0000, 82, 0);
    tbl[9]  = mk(6'b000010, 0, 0, 1, 1, 41, 81, 112, 8'b0000_0000, 100, 1);
    tbl[10] = mk(6'b000001, 0, 0, 0, 2, 3, 10, 112, 8'b0000_0001, 11, 0);

    rst_n = 1'b0; keys = '0; run = 1'b0;
    mftp0 = 1'b0; mftp1 = 1'b0; mftp2 = 1'b0;
    repeat (3) @(negedge clk);
    check(outs() == 10'b0, "reset_state", int'(outs()), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 11; t++) begin
      press(tbl[t].keys, tbl[t].run, tbl[t].bounce, tbl[t].sil, tbl[t].d0, tbl[t].d1,
            tbl[t].d2, tbl[t].hold, $sformatf("vec%0d", t));
      for (int i = 0; i < 8; i++)
        check(scnt[i] == int'(tbl[t].strb[i]), $sformatf("vec%0d_count%0d", t, i),
              scnt[i], int'(tbl[t].strb[i]));
      check(nreq == tbl[t].nreq, $sformatf("vec%0d_req_cycles", t), nreq, tbl[t].nreq);
      check(key_err == tbl[t].err, $sformatf("vec%0d_key_err", t), int'(key_err),
            int'(tbl[t].err));
    end

    // Retry of a silent START, then asynchronous reset in the middle of WAIT.
    gsilent = 1'b1;
    @(negedge clk);
    keys = 6'b000010; run = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    check(mft_req == 1'b1, "retry_req_high", int'(mft_req), 1);
    #2 rst_n = 1'b0;
    #1 check(outs() == 10'b0, "reset_mid_wait", int'(outs()), 0);
    keys = '0;
    err_model = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 16; n++) begin
      logic [5:0] k;
      bit         r, s;
      int         sel, d0, d1, d2;
      sel = $urandom_range(0, 9);
      if (sel <= 5) k = 6'(1 << sel);
      else if (sel == 6) k = 6'($urandom_range(0, 63));
      else k = 6'(1 << $urandom_range(0, 4));
      r  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 7) == 0);
      d0 = $urandom_range(1, 20);
      d1 = $urandom_range(d0, 50);
      d2 = $urandom_range(d1, 90);
      press(k, r, 1'b0, s, d0, d1, d2, 112, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
